// File: rtl/mac_dot_sched.sv
`timescale 1ns/1ps
// mac_dot_sched: dot-product job sequencer for a single binary32 MAC unit.
// Accepts a length-N job, clears the accumulator, streams N operand pairs
// into the MAC, waits out the MAC pipeline and returns the accumulated result.
module mac_dot_sched #(
  parameter int DW      = 32,
  parameter int LEN_W   = 10,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  input  logic [DW-1:0]    mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic             busy
);

  // Drain counter must hold MAC_LAT; keep at least one bit for MAC_LAT == 0.
  localparam int DCW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_d;
  logic [DCW-1:0]   dcnt;
  logic [DCW-1:0]   dcnt_d;
  logic             mac_clr_d;
  logic             mac_en_d;
  logic             res_valid_d;
  logic [DW-1:0]    mac_a_d;
  logic [DW-1:0]    mac_b_d;
  logic [DW-1:0]    res_data_d;
  logic             cmd_fire;
  logic             in_fire;

  // Handshake ready signals are straight state decodes; cmd_ready is held low during reset.
  assign cmd_ready = (state == S_IDLE) & ~rst;
  assign in_ready  = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign in_fire   = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          next_state = (cmd_len == '0) ? S_DONE : S_CLEAR;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_CLEAR: begin
        next_state = S_STREAM;
      end
      S_STREAM: begin
        if (in_fire && (cnt == LEN_W'(1))) begin
          next_state = S_DRAIN;
        end else begin
          next_state = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (dcnt == '0) begin
          next_state = S_DONE;
        end else begin
          next_state = S_DRAIN;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_DONE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Next values for counters and registered outputs.
  always_comb begin
    cnt_d       = cnt;
    dcnt_d      = dcnt;
    mac_a_d     = mac_a;
    mac_b_d     = mac_b;
    res_data_d  = res_data;
    mac_clr_d   = (next_state == S_CLEAR);
    mac_en_d    = in_fire;
    res_valid_d = (next_state == S_DONE);
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          cnt_d = cmd_len;
          if (cmd_len == '0) begin
            res_data_d = '0;
          end else begin
            res_data_d = res_data;
          end
        end else begin
          cnt_d = cnt;
        end
      end
      S_STREAM: begin
        if (in_fire) begin
          mac_a_d = in_a;
          mac_b_d = in_b;
          cnt_d   = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            dcnt_d = DCW'(MAC_LAT);
          end else begin
            dcnt_d = dcnt;
          end
        end else begin
          cnt_d = cnt;
        end
      end
      S_DRAIN: begin
        // Final product reaches mac_out MAC_LAT cycles after the last mac_en cycle.
        if (dcnt == '0) begin
          res_data_d = mac_out;
        end else begin
          dcnt_d = dcnt - DCW'(1);
        end
      end
      default: begin
        cnt_d = cnt;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      dcnt      <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      cnt       <= cnt_d;
      dcnt      <= dcnt_d;
      mac_clr   <= mac_clr_d;
      mac_en    <= mac_en_d;
      mac_a     <= mac_a_d;
      mac_b     <= mac_b_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_sched.sv
`timescale 1ns/1ps
// tb_mac_dot_sched: directed self-checking bench with a small integer-valued MAC model.
module tb_mac_dot_sched;

  localparam int DW    = 32;
  localparam int LEN_W = 10;

  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F5  = 32'h40A0_0000;
  localparam logic [31:0] F8  = 32'h4100_0000;
  localparam logic [31:0] F9  = 32'h4110_0000;
  localparam logic [31:0] F25 = 32'h41C8_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_a = '0;
  logic [DW-1:0]    in_b = '0;
  logic             mac_clr;
  logic             mac_en;
  logic [DW-1:0]    mac_a;
  logic [DW-1:0]    mac_b;
  logic [DW-1:0]    mac_out = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [DW-1:0]    res_data;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;
  int clr_cnt = 0;
  int en_cnt = 0;
  int both_cnt = 0;
  int acc = 0;

  mac_dot_sched #(.DW(DW), .LEN_W(LEN_W), .MAC_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int f2i(input logic [31:0] f);
    case (f)
      F1:      return 1;
      F2:      return 2;
      F3:      return 3;
      F5:      return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] i2f(input int v);
    case (v)
      0:       return 32'h0000_0000;
      2:       return 32'h4000_0000;
      4:       return 32'h4080_0000;
      6:       return 32'h40C0_0000;
      8:       return F8;
      9:       return F9;
      25:      return F25;
      default: return 32'h7FC0_0000;
    endcase
  endfunction

  // MAC model: product lands in acc one cycle after mac_en, on mac_out one cycle later.
  always @(posedge clk) begin
    if (mac_clr) acc <= 0;
    else if (mac_en) acc <= acc + f2i(mac_a) * f2i(mac_b);
    mac_out <= i2f(acc);
    if (mac_clr) clr_cnt <= clr_cnt + 1;
    if (mac_en) en_cnt <= en_cnt + 1;
    if (mac_clr && mac_en) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len);
    chk("cmd_ready_pre", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(n < 20), 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mac_en", 32'(mac_en), 32'd1);
    chk("mac_a", mac_a, a);
    chk("mac_b", mac_b, b);
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int c0;
    int e0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mac_clr", 32'(mac_clr), 32'd0);
    chk("rst_mac_en", 32'(mac_en), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);

    // 1) N=1, 5.0*5.0
    res_ready = 1'b1;
    c0 = clr_cnt; e0 = en_cnt;
    send_cmd(10'd1);
    chk("t1_mac_clr", 32'(mac_clr), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
    feed(F5, F5);
    chk("t1_in_ready_drop", 32'(in_ready), 32'd0);
    wait_res(n);
    chk("t1_latency", n, 32'd3);
    chk("t1_res_data", res_data, F25);
    @(negedge clk);
    chk("t1_res_valid_clr", 32'(res_valid), 32'd0);
    chk("t1_cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("t1_clr_pulses", clr_cnt - c0, 32'd1);
    chk("t1_en_cycles", en_cnt - e0, 32'd1);

    // 2) N=4, (1.0,2.0) back-to-back
    e0 = en_cnt;
    send_cmd(10'd4);
    repeat (4) feed(F1, F2);
    wait_res(n);
    chk("t2_latency", n, 32'd3);
    chk("t2_res_data", res_data, F8);
    chk("t2_en_cycles", en_cnt - e0, 32'd4);
    @(negedge clk);

    // 3) N=4 with a 3-cycle gap between pairs 2 and 3
    e0 = en_cnt;
    send_cmd(10'd4);
    feed(F1, F2);
    feed(F1, F2);
    repeat (3) begin
      @(negedge clk);
      chk("t3_gap_mac_en", 32'(mac_en), 32'd0);
      chk("t3_gap_mac_a_hold", mac_a, F1);
    end
    feed(F1, F2);
    feed(F1, F2);
    wait_res(n);
    chk("t3_latency", n, 32'd3);
    chk("t3_res_data", res_data, F8);
    chk("t3_en_cycles", en_cnt - e0, 32'd4);
    @(negedge clk);

    // 4) N=0
    c0 = clr_cnt; e0 = en_cnt;
    send_cmd(10'd0);
    chk("t4_res_valid", 32'(res_valid), 32'd1);
    chk("t4_res_data", res_data, 32'd0);
    @(negedge clk);
    chk("t4_res_valid_clr", 32'(res_valid), 32'd0);
    chk("t4_clr_pulses", clr_cnt - c0, 32'd0);
    chk("t4_en_cycles", en_cnt - e0, 32'd0);

    // 5) Back-pressure in DONE; cmd_valid during job not acked
    res_ready = 1'b0;
    e0 = en_cnt;
    send_cmd(10'd1);
    cmd_valid = 1'b1;
    cmd_len   = 10'd5;
    chk("t5_cmd_ready_clear", 32'(cmd_ready), 32'd0);
    feed(F3, F3);
    chk("t5_cmd_ready_drain", 32'(cmd_ready), 32'd0);
    wait_res(n);
    chk("t5_latency", n, 32'd3);
    repeat (10) begin
      chk("t5_hold_valid", 32'(res_valid), 32'd1);
      chk("t5_hold_data", res_data, F9);
      chk("t5_cmd_ready_done", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t5_res_valid_clr", 32'(res_valid), 32'd0);
    chk("t5_cmd_ready_back", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("t5_no_new_job", 32'(busy), 32'd0);
    chk("t5_en_cycles", en_cnt - e0, 32'd1);

    // 6) Reset mid-STREAM, then a fresh N=1 job
    send_cmd(10'd4);
    feed(F1, F2);
    feed(F1, F2);
    rst = 1'b1;
    #1;
    chk("t6_rst_mac_en", 32'(mac_en), 32'd0);
    chk("t6_rst_mac_a", mac_a, 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    e0 = en_cnt;
    send_cmd(10'd1);
    feed(F3, F3);
    wait_res(n);
    chk("t6_latency", n, 32'd3);
    chk("t6_res_data", res_data, F9);
    chk("t6_en_cycles", en_cnt - e0, 32'd1);
    @(negedge clk);
    chk("t6_res_valid_clr", 32'(res_valid), 32'd0);
    chk("clr_en_exclusive", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
